fifo_param: RTL
===============

# fifo_param

Parametrised synchronous FIFO with integrated controller: data memory, head/tail pointers, occupancy counter, registered state machine and status flags. Generalises the fixed 8-deep FIFO controller with configurable width and depth, simultaneous read/write in one cycle, and programmable almost-full/almost-empty thresholds. Sits between a producer and a consumer in the same clock domain; the next-state decision is factored into its own combinational sub-module.

## Interface
- DATA_WIDTH, 32, width of each stored word
- DEPTH, 8, number of entries; power of two, minimum 2
- AW, log2(DEPTH), pointer width; derived, not overridden
- AF_TH, DEPTH-1, almost_full asserts when data_count >= AF_TH
- AE_TH, 1, almost_empty asserts when data_count <= AE_TH

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- opclear  in  1  synchronous clear, highest priority after reset
- wr_en  in  1  write request
- rd_en  in  1  read request
- d_in  in  DATA_WIDTH  write data
- d_out  out  DATA_WIDTH  read data, registered
- data_count  out  AW+1  current occupancy 0..DEPTH
- state  out  3  current state register
- full / empty  out  1  data_count == DEPTH / data_count == 0
- almost_full / almost_empty  out  1  threshold flags per parameters
- wr_ack / wr_err  out  1  previous-cycle write accepted / rejected
- rd_ack / rd_err  out  1  previous-cycle read accepted / rejected

## Operation
- States (3-bit): INIT=000, NO_OP=001, WRITE=010, WR_ERROR=011, READ=100, RD_ERROR=101, RDWR=110.
- Next-state priority, evaluated on current data_count:
  - opclear -> INIT
  - rd_en & !wr_en & empty -> RD_ERROR
  - wr_en & !rd_en & full -> WR_ERROR
  - rd_en & !wr_en -> READ
  - wr_en & !rd_en -> WRITE
  - wr_en & rd_en & empty -> WRITE (write only; read dropped, no error)
  - wr_en & rd_en & !empty -> RDWR (including full)
  - otherwise -> NO_OP
- Datapath per next state, same edge as state update:
  - WRITE: mem[tail] <= d_in, tail+1, count+1
  - READ: d_out <= mem[head], head+1, count-1
  - RDWR: both of the above, count unchanged; when full, the read slot is freed and reused in the same cycle without corruption
  - INIT: head, tail, count, d_out <= 0; memory contents not cleared
  - NO_OP / WR_ERROR / RD_ERROR: no pointer, count, memory or d_out change
- Pointers are AW bits and wrap DEPTH-1 -> 0 naturally.
- Outputs decoded from state (Moore): wr_ack = WRITE|RDWR; rd_ack = READ|RDWR; wr_err = WR_ERROR; rd_err = RD_ERROR.
- full, empty and almost flags are combinational from registered data_count.

## Timing
- Reset (reset_n low, asynchronous): state=INIT, head=tail=0, data_count=0, d_out=0. Resulting flags: empty=1, almost_empty=1, full=0, all acks/errs 0.
- Reset mid-operation discards contents logically; the first post-reset read is RD_ERROR.
- Request sampled at edge N; state, acks, d_out and count valid after edge N (one cycle latency).
- Back-to-back requests every cycle are supported at full throughput.
- opclear asserted with wr_en/rd_en: clear wins, no write stored.
- d_out holds its last value until the next accepted read.

## Structure
- Shared constants file: the seven state encodings and state width, included by both modules.
- Sub-module fifo_param_ns: combinational next-state logic (inputs opclear, wr_en, rd_en, data_count; output next_state); parametrised by DEPTH.
- Top contains the state register, pointers, counter, memory array and output decode.

## Test plan
- Reset then rd_en=1 -> state RD_ERROR, rd_err=1, data_count=0, d_out=0.
- Write 0x1..0x8 (DEPTH=8) -> data_count=8, full=1, almost_full from count 7; ninth write -> WR_ERROR, count stays 8.
- Read all 8 -> d_out 0x1..0x8 in order, empty=1 after the 8th, almost_empty at count<=1.
- Fill to 8, then 4 cycles of wr_en=rd_en=1 with 0xA..0xD -> state RDWR, count stays 8, full stays 1; subsequent reads return 0x5..0x8 then 0xA..0xD (pointer wrap).
- Empty FIFO, wr_en=rd_en=1 with 0x55 -> state WRITE, count=1, no rd_err; next read returns 0x55.
- Fill 3 words, pulse opclear together with wr_en -> INIT, count=0, d_out=0; async reset_n pulse mid-burst -> immediate INIT, empty=1.

Source files
------------

// File: rtl/fifo_param_pkg.sv
// Shared state encodings for the parametrised FIFO and helpers that decode
// which datapath operations a state performs.
package fifo_param_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_INIT     = 3'b000,
        ST_NO_OP    = 3'b001,
        ST_WRITE    = 3'b010,
        ST_WR_ERROR = 3'b011,
        ST_READ     = 3'b100,
        ST_RD_ERROR = 3'b101,
        ST_RDWR     = 3'b110
    } state_e;

    function automatic logic st_writes(state_e s);
        return (s == ST_WRITE) || (s == ST_RDWR);
    endfunction

    function automatic logic st_reads(state_e s);
        return (s == ST_READ) || (s == ST_RDWR);
    endfunction

endpackage

// File: rtl/fifo_param_ns.sv
// Combinational next-state decision for the FIFO controller, evaluated on the
// registered occupancy.
module fifo_param_ns
    import fifo_param_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     opclear,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH):0]   data_count,
    output logic [STATE_W-1:0]       next_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic is_empty;
    logic is_full;

    assign is_empty = (data_count == '0);
    assign is_full  = (data_count == FULL_CNT);

    // A combined request on an empty FIFO degrades to a plain write, no error.
    always_comb begin
        next_state = ST_NO_OP;
        if (opclear)
            next_state = ST_INIT;
        else if (rd_en && !wr_en && is_empty)
            next_state = ST_RD_ERROR;
        else if (wr_en && !rd_en && is_full)
            next_state = ST_WR_ERROR;
        else if (rd_en && !wr_en)
            next_state = ST_READ;
        else if (wr_en && !rd_en)
            next_state = ST_WRITE;
        else if (wr_en && rd_en && is_empty)
            next_state = ST_WRITE;
        else if (wr_en && rd_en)
            next_state = ST_RDWR;
    end

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: memory, head/tail pointers, occupancy counter,
// registered Moore state machine and threshold flags.
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AF_TH      = DEPTH - 1,
    parameter int AE_TH      = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     opclear,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [DATA_WIDTH-1:0]    d_in,
    output logic [DATA_WIDTH-1:0]    d_out,
    output logic [$clog2(DEPTH):0]   data_count,
    output logic [STATE_W-1:0]       state,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     wr_ack,
    output logic                     wr_err,
    output logic                     rd_ack,
    output logic                     rd_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_TH);
    localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_TH);

    state_e                  state_q;
    state_e                  state_d;
    logic [STATE_W-1:0]      ns_raw;
    logic [AW-1:0]           head_q, head_d;
    logic [AW-1:0]           tail_q, tail_d;
    logic [AW:0]             count_q, count_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    fifo_param_ns #(
        .DEPTH      (DEPTH)
    ) u_ns (
        .opclear    (opclear),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .data_count (count_q),
        .next_state (ns_raw)
    );

    assign state_d = state_e'(ns_raw);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= ST_INIT;
        else
            state_q <= state_d;
    end

    // Datapath follows the state being entered, so it updates on the same edge.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        dout_d  = dout_q;
        case (state_d)
            ST_INIT: begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                dout_d  = '0;
            end
            ST_WRITE: begin
                tail_d  = tail_q + AW'(1);
                count_d = count_q + (AW+1)'(1);
            end
            ST_READ: begin
                dout_d  = mem_q[head_q];
                head_d  = head_q + AW'(1);
                count_d = count_q - (AW+1)'(1);
            end
            ST_RDWR: begin
                dout_d  = mem_q[head_q];
                head_d  = head_q + AW'(1);
                tail_d  = tail_q + AW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    // When full, head == tail: the read above samples the old word before this
    // write replaces it, so the freed slot is reused without corruption.
    always_ff @(posedge clk) begin
        if (reset_n && st_writes(state_d))
            mem_q[tail_q] <= d_in;
    end

    always_comb begin
        wr_ack = st_writes(state_q);
        rd_ack = st_reads(state_q);
        wr_err = (state_q == ST_WR_ERROR);
        rd_err = (state_q == ST_RD_ERROR);
    end

    assign state        = state_q;
    assign d_out        = dout_q;
    assign data_count   = count_q;
    assign full         = (count_q == FULL_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);

endmodule
